// File: rtl/pacman_pkg.sv
// pacman_pkg: shared grid geometry, direction encoding and neighbour helper.
//   GRID_BITS  - width of one grid coordinate (32x32 board)
//   ADDR_BITS  - width of a maze cell address {y,x}
//   dir_t      - heading encoding 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT
//   neighbour  - adjacent cell address with tunnel wrap on every edge
package pacman_pkg;
    localparam int GRID_BITS = 5;
    localparam int ADDR_BITS = 10;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_PEND,
        CHK_PEND,
        RD_CUR,
        CHK_CUR
    } mc_state_t;

    // Coordinates are plain modulo-32 counters, so the tunnel wrap falls out
    // of the natural overflow of the 5-bit add/subtract.
    function automatic logic [ADDR_BITS-1:0] neighbour(
        input logic [GRID_BITS-1:0] x,
        input logic [GRID_BITS-1:0] y,
        input dir_t                 d
    );
        logic [GRID_BITS-1:0] nx;
        logic [GRID_BITS-1:0] ny;
        nx = d == DIR_RIGHT ? x + GRID_BITS'(1) : d == DIR_LEFT ? x - GRID_BITS'(1) : x;
        ny = d == DIR_DOWN  ? y + GRID_BITS'(1) : d == DIR_UP   ? y - GRID_BITS'(1) : y;
        return {ny, nx};
    endfunction
endpackage

// File: rtl/step_detect.sv
// step_detect: one-cycle step pulse on every edge of the divided tick.
//   clk, reset - clock and synchronous active-high reset
//   tick_src   - slow toggling tick, already registered in the clk domain
//   step       - high for the cycle in which tick_src differs from its history
module step_detect (
    input  logic clk,
    input  logic reset,
    input  logic tick_src,
    output logic step
);
    logic tick_q;

    // The history tracks tick_src through reset as well, so the first cycle
    // after reset never sees a spurious edge.
    always_ff @(posedge clk) tick_q <= tick_src;

    assign step = !reset && (tick_src ^ tick_q);
endmodule

// File: rtl/move_controller.sv
// move_controller: grid mover that tries the requested heading, falls back to the current one.
//   clk, reset          - clock and synchronous active-high reset
//   en, tick_src        - step enable and divided tick (a step per tick edge)
//   dir_req, dir_valid  - requested heading and its one-cycle qualifier
//   maze_rd, maze_addr  - wall lookup strobe and {y,x} address (addr held between reads)
//   maze_wall           - wall bit returned one cycle after maze_rd
//   pos_x, pos_y, cur_dir - current position and heading
//   moved, blocked, busy  - step outcome pulses and FSM-active flag
module move_controller
    import pacman_pkg::*;
#(
    parameter logic [GRID_BITS-1:0] START_X   = 5'd14,
    parameter logic [GRID_BITS-1:0] START_Y   = 5'd23,
    parameter logic [1:0]           START_DIR = 2'd3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 tick_src,
    input  logic [1:0]           dir_req,
    input  logic                 dir_valid,
    output logic                 maze_rd,
    output logic [ADDR_BITS-1:0] maze_addr,
    input  logic                 maze_wall,
    output logic [GRID_BITS-1:0] pos_x,
    output logic [GRID_BITS-1:0] pos_y,
    output logic [1:0]           cur_dir,
    output logic                 moved,
    output logic                 blocked,
    output logic                 busy
);
    mc_state_t state, state_nx;
    dir_t      cur_d, pend_dir, work_dir;
    logic      step, step_pending, take, fallback;

    step_detect u_step (
        .clk     (clk),
        .reset   (reset),
        .tick_src(tick_src),
        .step    (step)
    );

    assign take     = state == IDLE && step_pending;
    assign fallback = state == CHK_PEND && maze_wall && work_dir != cur_d;
    assign cur_dir  = cur_d;
    assign busy     = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pos_x        <= START_X;
            pos_y        <= START_Y;
            cur_d        <= dir_t'(START_DIR);
            pend_dir     <= dir_t'(START_DIR);
            work_dir     <= dir_t'(START_DIR);
            step_pending <= 1'b0;
            maze_addr    <= '0;
        end else begin
            state <= state_nx;
            if (dir_valid) pend_dir <= dir_t'(dir_req);
            // A new step event beats the clear, so a tick landing on the
            // IDLE->RD_PEND cycle is kept as the next pending step.
            if (step && en) step_pending <= 1'b1;
            else if (take) step_pending <= 1'b0;
            if (take) begin
                work_dir  <= pend_dir;
                maze_addr <= neighbour(pos_x, pos_y, pend_dir);
            end
            if (fallback) maze_addr <= neighbour(pos_x, pos_y, cur_d);
            // maze_addr still holds the neighbour just checked, so it is the new position.
            if (moved) {pos_y, pos_x} <= maze_addr;
            if (state == CHK_PEND && !maze_wall) cur_d <= work_dir;
        end
    end

    always_comb begin
        state_nx = state;
        maze_rd  = 1'b0;
        moved    = 1'b0;
        blocked  = 1'b0;
        case (state)
            IDLE:     state_nx = step_pending ? RD_PEND : IDLE;
            RD_PEND: begin
                maze_rd  = 1'b1;
                state_nx = CHK_PEND;
            end
            CHK_PEND: begin
                moved    = !maze_wall;
                blocked  = maze_wall && work_dir == cur_d;
                state_nx = fallback ? RD_CUR : IDLE;
            end
            RD_CUR: begin
                maze_rd  = 1'b1;
                state_nx = CHK_CUR;
            end
            CHK_CUR: begin
                moved    = !maze_wall;
                blocked  = maze_wall;
                state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller: directed and random steps checked against a step-level model.
module tb_move_controller;
    logic       clk = 0;
    logic       reset, en, tick_src, dir_valid, maze_wall;
    logic [1:0] dir_req;
    logic       maze_rd, moved, blocked, busy;
    logic [9:0] maze_addr;
    logic [4:0] pos_x, pos_y;
    logic [1:0] cur_dir;

    bit walls [1024];
    int tests = 0, failed = 0;
    int mx, my, md, mp;

    move_controller dut (
        .clk(clk), .reset(reset), .en(en), .tick_src(tick_src),
        .dir_req(dir_req), .dir_valid(dir_valid),
        .maze_rd(maze_rd), .maze_addr(maze_addr), .maze_wall(maze_wall),
        .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir),
        .moved(moved), .blocked(blocked), .busy(busy)
    );

    always #5 clk = !clk;

    // Maze memory: registered read, junk whenever no read was issued.
    always @(posedge clk) maze_wall <= maze_rd ? walls[maze_addr] : 1'($urandom);

    function automatic int nbx(input int x, input int d);
        return (x + (d == 1 ? 1 : 0) - (d == 3 ? 1 : 0) + 32) % 32;
    endfunction

    function automatic int nby(input int y, input int d);
        return (y + (d == 2 ? 1 : 0) - (d == 0 ? 1 : 0) + 32) % 32;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_walls();
        for (int i = 0; i < 1024; i++) walls[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_dir(input int d);
        dir_req = 2'(d);
        dir_valid = 1;
        tick();
        dir_valid = 0;
        mp = d;
    endtask

    // One tick edge, then follow the step to its outcome. Expected outcome comes
    // from the movement rules: try the pending heading, else the current one.
    task automatic run_step(input string tag, input bit drop_en);
        int a1, a2, nl, lat, ex, ey, ed, done, nrd;
        bit mv;
        a1 = nby(my, mp) * 32 + nbx(mx, mp);
        a2 = nby(my, md) * 32 + nbx(mx, md);
        if (!walls[a1]) begin
            mv = 1; lat = 3; nl = 1; ex = nbx(mx, mp); ey = nby(my, mp); ed = mp;
        end else if (mp != md) begin
            mv = !walls[a2]; lat = 5; nl = 2; ed = md;
            ex = mv ? nbx(mx, md) : mx;
            ey = mv ? nby(my, md) : my;
        end else begin
            mv = 0; lat = 3; nl = 1; ex = mx; ey = my; ed = md;
        end
        tick_src = !tick_src;
        done = -1;
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (maze_rd) begin
                nrd++;
                check({tag, "_addr"}, int'(maze_addr), nrd == 1 ? a1 : a2);
            end
            if (moved || blocked) begin
                done = c;
                break;
            end
            tick();
            if (drop_en && c == 0) en = 0;
        end
        check({tag, "_latency"}, done, lat);
        check({tag, "_moved"}, int'(moved), int'(mv));
        check({tag, "_blocked"}, int'(blocked), int'(!mv));
        check({tag, "_lookups"}, nrd, nl);
        tick();
        en = 1;
        check({tag, "_x"}, int'(pos_x), ex);
        check({tag, "_y"}, int'(pos_y), ey);
        check({tag, "_dir"}, int'(cur_dir), ed);
        check({tag, "_idle"}, int'(busy), 0);
        mx = ex; my = ey; md = ed;
    endtask

    initial begin
        int n_mv, n_rd;
        reset = 1; en = 1; tick_src = 0; dir_valid = 0; dir_req = 0;
        clear_walls();
        tick();
        tick();
        tick_src = 1;
        tick();
        reset = 0;
        mx = 14; my = 23; md = 3; mp = 3;
        check("rst_x", int'(pos_x), 14);
        check("rst_y", int'(pos_y), 23);
        check("rst_dir", int'(cur_dir), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_rd", int'(maze_rd), 0);
        check("rst_addr", int'(maze_addr), 0);
        check("rst_moved", int'(moved), 0);
        check("rst_blocked", int'(blocked), 0);
        n_rd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_rd += int'(busy) + int'(maze_rd);
            tick();
        end
        check("rst_no_step", n_rd, 0);

        run_step("open", 0);
        set_dir(0);
        run_step("turn", 0);
        set_dir(3);
        run_step("left", 0);
        set_dir(0);
        walls[nby(my, 0) * 32 + nbx(mx, 0)] = 1;
        run_step("fallback", 0);
        set_dir(3);
        walls[nby(my, 3) * 32 + nbx(mx, 3)] = 1;
        run_step("deadend", 0);
        clear_walls();
        run_step("en_drop", 1);
        while (mx != 0) run_step("walk", 0);
        run_step("wrap_left", 0);
        set_dir(1);
        run_step("wrap_right", 0);

        // Tick edges on the take cycle and while busy: exactly one extra step.
        n_mv = 0; n_rd = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 3) tick_src = !tick_src;
            @(negedge clk);
            n_mv += int'(moved);
            n_rd += int'(maze_rd);
            tick();
        end
        check("collapse_moves", n_mv, 2);
        check("collapse_rds", n_rd, 2);
        check("collapse_x", int'(pos_x), 2);
        mx = 2;

        en = 0;
        tick_src = !tick_src;
        n_rd = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 6) en = 1;
            @(negedge clk);
            n_rd += int'(maze_rd) + int'(busy);
            tick();
        end
        check("en_off_no_rd", n_rd, 0);

        tick_src = !tick_src;
        tick();
        tick();
        tick();
        check("mid_busy", int'(busy), 1);
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("midrst_x", int'(pos_x), 14);
        check("midrst_y", int'(pos_y), 23);
        check("midrst_dir", int'(cur_dir), 3);
        check("midrst_busy", int'(busy), 0);
        tick();
        mx = 14; my = 23; md = 3; mp = 3;

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 1024; j++) walls[j] = ($urandom % 3) == 0;
            if ($urandom % 2 == 1) set_dir(int'($urandom % 4));
            repeat ($urandom % 3) tick();
            run_step("rand", 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have parameter START_X, default 5'd14, the reset column.
REQ-002 SHALL have parameter START_Y, default 5'd23, the reset row.
REQ-003 SHALL have parameter START_DIR, default 2'd3 (LEFT), the reset heading.
REQ-004 SHALL have port clk  in  1  clock; all logic on posedge clk.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port en  in  1  step enable.
REQ-007 SHALL have port tick_src  in  1  slowed toggling clock from the rate divider, clk-domain register output.
REQ-008 SHALL have port dir_req  in  2  requested direction: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT.
REQ-009 SHALL have port dir_valid  in  1  dir_req qualifier, one cycle.
REQ-010 SHALL have port maze_rd  out  1  maze wall lookup strobe.
REQ-011 SHALL have port maze_addr  out  10  lookup cell address {y,x}.
REQ-012 SHALL have port maze_wall  in  1  wall bit, valid exactly 1 cycle after maze_rd.
REQ-013 SHALL have port pos_x  out  5  current column.
REQ-014 SHALL have port pos_y  out  5  current row.
REQ-015 SHALL have port cur_dir  out  2  current heading.
REQ-016 SHALL have port moved  out  1  one-cycle pulse on position update.
REQ-017 SHALL have port blocked  out  1  one-cycle pulse when a step ends without a move.
REQ-018 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-019 SHALL generate a step event on every transition (0->1 and 1->0) of tick_src, detected against a registered copy; one step per divider interval.
REQ-020 SHALL latch dir_req into pend_dir on any cycle with dir_valid=1, regardless of en or FSM state; last write wins.
REQ-021 SHALL set step_pending on a step event when en=1; step events with en=0 are discarded; events while busy collapse into one pending step.
REQ-022 SHALL implement FSM states IDLE, RD_PEND, CHK_PEND, RD_CUR, CHK_CUR.
REQ-023 SHALL transition IDLE->RD_PEND when step_pending=1, clearing step_pending; pend_dir sampled into a working register at this transition.
REQ-024 SHALL in RD_PEND assert maze_rd=1 for one cycle, with maze_addr equal to the neighbour cell in the working direction, and go to CHK_PEND.
REQ-025 SHALL in CHK_PEND with maze_wall=0 update pos to the neighbour, set cur_dir to the working direction, pulse moved, and go to IDLE.
REQ-026 SHALL in CHK_PEND with maze_wall=1 go to RD_CUR if the working direction != cur_dir; otherwise pulse blocked and go to IDLE.
REQ-027 SHALL in RD_CUR issue the lookup for the neighbour in cur_dir and go to CHK_CUR.
REQ-028 SHALL in CHK_CUR move in cur_dir (pulse moved) if maze_wall=0, else pulse blocked; in both cases go to IDLE with cur_dir unchanged.
REQ-029 SHALL compute the neighbour with 5-bit modular arithmetic: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1; x=31 RIGHT ->0, x=0 LEFT ->31, same for y (tunnel wrap).
REQ-030 SHALL complete an in-flight step when en falls mid-step.
REQ-031 SHALL treat a step event arriving on the same cycle as the IDLE->RD_PEND transition as a new pending step.
REQ-032 SHALL complete each step in 3 cycles (pending direction open) or 5 cycles (fallback) after leaving IDLE.
REQ-033 SHALL hold maze_addr at its last value when maze_rd=0.

Reset
REQ-034 SHALL on reset set pos_x=START_X, pos_y=START_Y, cur_dir=START_DIR, pend_dir=START_DIR, state=IDLE, step_pending=0, maze_rd=0, maze_addr=0, moved=0, blocked=0, busy=0.
REQ-035 SHALL on reset load the tick_src history register with the current tick_src, so that no step is generated on the first cycle after reset.
REQ-036 SHALL let reset override all activity, including a step in flight.

Structure
REQ-037 SHALL take direction encodings, GRID_BITS=5 and ADDR_BITS=10 from shared package pacman_pkg.
REQ-038 SHALL place transition detection in sub-module step_detect (inputs clk, reset, tick_src; output step pulse).

Verification
REQ-039 SHALL test an open cell: pos (14,23), cur_dir LEFT, all maze_wall=0, one tick_src toggle -> maze_addr={23,13}, then pos_x=13 with moved pulsed 3 cycles after the step.
REQ-040 SHALL test a turn: dir_valid with UP, maze_wall=0 -> cur_dir=UP, pos_y=22.
REQ-041 SHALL test the fallback: pend UP with a wall and LEFT open -> second lookup, pos_x-1, cur_dir stays LEFT, moved pulsed 5 cycles after the step.
REQ-042 SHALL test a dead end: pend==cur with a wall -> a single lookup, blocked pulse, pos unchanged.
REQ-043 SHALL test wrap: pos_x=0 LEFT, open cell -> pos_x=31; pos_x=31 RIGHT, open cell -> pos_x=0.
REQ-044 SHALL test control timing: two toggles while busy -> exactly one extra step; toggle with en=0 -> no maze_rd; reset during CHK_PEND -> pos=(14,23), busy=0 the next cycle.
